// File: rtl/logic_op_sequencer_if.sv
// Instruction byte stream between issuer and logic_op_sequencer.
// Single valid/ready handshake carrying one byte per beat.
interface logic_op_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );
endinterface

// File: rtl/logic_op_sequencer.sv
// Logical-instruction sequencer: decode, operand fetch, writeback.
// Optional status flags enabled by defining LOGIC_SEQ_FLAGS_EN.
module logic_op_sequencer #(
  parameter logic [1:0] LOGIC_MODE = 2'b01,
  parameter int         NUM_REGS   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  logic_op_sequencer_if.slave  s_instr,
  input  logic                 reg_wr_en,
  input  logic [1:0]           reg_wr_addr,
  input  logic [7:0]           reg_wr_data,
  output logic                 reg_wr_ready,
  input  logic [1:0]           rd_addr,
  output logic [7:0]           rd_data,
  output logic [2:0]           lu_opcode,
  output logic [7:0]           lu_operand_a,
  output logic [7:0]           lu_operand_b,
  input  logic [7:0]           lu_result,
  output logic                 done,
  output logic                 illegal,
`ifdef LOGIC_SEQ_FLAGS_EN
  output logic                 flag_zero,
  output logic                 flag_neg,
`endif
  output logic [7:0]           result
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SELECT = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0] r_state;
  logic [7:0] r_byte0;
  logic [5:0] r_sel;
  logic       r_illegal;
  logic [7:0] r_rf [NUM_REGS];
  logic [7:0] r_result;

  logic       w_idle;
  logic       w_select;
  logic       w_exec;
  logic       w_done;
  logic       w_accept;
  logic       w_legal;
  logic       w_load;
  logic [2:0] w_op;
  logic [1:0] w_dst;
  logic [1:0] w_src_a;
  logic [1:0] w_src_b;

  assign w_idle   = (r_state == S_IDLE);
  assign w_select = (r_state == S_SELECT);
  assign w_exec   = (r_state == S_EXEC);
  assign w_done   = (r_state == S_DONE);

  assign s_instr.instr_ready = w_idle | w_select;
  assign reg_wr_ready        = w_idle;

  assign w_accept = s_instr.instr_valid & s_instr.instr_ready;
  assign w_load   = reg_wr_en & reg_wr_ready;

  assign w_op    = r_byte0[2:0];
  assign w_dst   = r_sel[5:4];
  assign w_src_a = r_sel[3:2];
  assign w_src_b = r_sel[1:0];

  // Only AND/OR/NAND/NOR exist, so op[2] must be clear
  assign w_legal = (r_byte0[7:6] == LOGIC_MODE) &&
                   (r_byte0[5:3] == 3'b000) &&
                   !r_byte0[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_byte0   <= '0;
      r_sel     <= '0;
      r_illegal <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_byte0 <= s_instr.instr;
            r_state <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (w_accept) begin
            r_sel     <= s_instr.instr[5:0];
            r_illegal <= !w_legal;
            r_state   <= w_legal ? S_EXEC : S_DONE;
          end
        end
        S_EXEC:  r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Writeback and external load are exclusive by state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_rf[i] <= '0;
      end
      r_result <= '0;
    end else begin
      if (w_exec) begin
        r_rf[w_dst] <= lu_result;
        r_result    <= lu_result;
      end else if (w_load) begin
        r_rf[reg_wr_addr] <= reg_wr_data;
      end
    end
  end

`ifdef LOGIC_SEQ_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_zero <= 1'b0;
      flag_neg  <= 1'b0;
    end else if (w_exec) begin
      flag_zero <= (lu_result == 8'h00);
      flag_neg  <= lu_result[7];
    end
  end
`endif

  always_comb begin
    lu_opcode    = '0;
    lu_operand_a = '0;
    lu_operand_b = '0;
    unique case (1'b1)
      w_exec: begin
        lu_opcode    = w_op;
        lu_operand_a = r_rf[w_src_a];
        lu_operand_b = r_rf[w_src_b];
      end
      default: ;
    endcase
  end

  assign done    = w_done;
  assign illegal = w_done & r_illegal;
  assign result  = r_result;
  assign rd_data = r_rf[rd_addr];

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Randomized self-checking bench for logic_op_sequencer.
// Define LOGIC_SEQ_FLAGS_EN to also check flag outputs.
module tb_logic_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       reg_wr_en;
  logic [1:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr_ready;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic [2:0] lu_opcode;
  logic [7:0] lu_operand_a;
  logic [7:0] lu_operand_b;
  logic [7:0] lu_result;
  logic       done;
  logic       illegal;
  logic [7:0] result;
`ifdef LOGIC_SEQ_FLAGS_EN
  logic       flag_zero;
  logic       flag_neg;
  logic       m_fz;
  logic       m_fn;
`endif

  logic [7:0] m_rf [4];
  logic [7:0] m_result;
  int         n_cmp = 0;
  int         n_err = 0;

  logic_op_sequencer_if bus ();

  always #5 clk = ~clk;

  logic_op_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .s_instr      (bus),
    .reg_wr_en    (reg_wr_en),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr_ready (reg_wr_ready),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .lu_opcode    (lu_opcode),
    .lu_operand_a (lu_operand_a),
    .lu_operand_b (lu_operand_b),
    .lu_result    (lu_result),
    .done         (done),
    .illegal      (illegal),
`ifdef LOGIC_SEQ_FLAGS_EN
    .flag_zero    (flag_zero),
    .flag_neg     (flag_neg),
`endif
    .result       (result)
  );

  function automatic logic [7:0] logic_fn(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign lu_result = logic_fn(lu_opcode, lu_operand_a, lu_operand_b);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf;
    for (int i = 0; i < 4; i++) begin
      rd_addr = i[1:0];
      #1;
      check($sformatf("rf%0d", i), rd_data, m_rf[i]);
    end
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    check("ld_rdy", reg_wr_ready, 1);
    reg_wr_en   = 1'b1;
    reg_wr_addr = a;
    reg_wr_data = d;
    step;
    reg_wr_en = 1'b0;
    m_rf[a]   = d;
  endtask

  // ld: 0 none, 1 alongside byte0, 2 held from SELECT until accepted
  task automatic send(input logic [7:0] b0, input logic [7:0] b1,
                      input int gap, input int ld,
                      input logic [1:0] la, input logic [7:0] ldd);
    logic       legal;
    logic [7:0] r;
    legal = (b0[7:6] == 2'b01) && (b0[5:3] == 3'b000) && !b0[2];
    check("idle_rdy", bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.instr       = b0;
    if (ld == 1) begin
      reg_wr_en = 1'b1; reg_wr_addr = la; reg_wr_data = ldd;
    end
    step;
    if (ld == 1) begin
      m_rf[la]  = ldd;
      reg_wr_en = 1'b0;
    end
    if (ld == 2) begin
      reg_wr_en = 1'b1; reg_wr_addr = la; reg_wr_data = ldd;
    end
    bus.instr_valid = 1'b0;
    bus.instr       = 8'($urandom);
    repeat (gap) begin
      check("sel_rdy", bus.instr_ready, 1);
      check("sel_done", done, 0);
      if (ld == 2) check("sel_wrrdy", reg_wr_ready, 0);
      step;
    end
    check("sel_rdy1", bus.instr_ready, 1);
    if (ld == 2) check("sel_wrrdy1", reg_wr_ready, 0);
    bus.instr_valid = 1'b1;
    bus.instr       = b1;
    step;
    bus.instr_valid = 1'b0;
    if (legal) begin
      r = logic_fn(b0[2:0], m_rf[b1[3:2]], m_rf[b1[1:0]]);
      check("ex_op", lu_opcode, b0[2:0]);
      check("ex_a", lu_operand_a, m_rf[b1[3:2]]);
      check("ex_b", lu_operand_b, m_rf[b1[1:0]]);
      check("ex_rdy", bus.instr_ready, 0);
      check("ex_done", done, 0);
      if (ld == 2) check("ex_wrrdy", reg_wr_ready, 0);
      step;
      m_rf[b1[5:4]] = r;
      m_result      = r;
`ifdef LOGIC_SEQ_FLAGS_EN
      m_fz = (r == 8'h00);
      m_fn = r[7];
`endif
    end
    check("dn_done", done, 1);
    check("dn_ill", illegal, !legal);
    check("dn_res", result, m_result);
    check("dn_rdy", bus.instr_ready, 0);
    check("dn_lu", {lu_opcode, lu_operand_a, lu_operand_b}, 0);
`ifdef LOGIC_SEQ_FLAGS_EN
    check("dn_fz", flag_zero, m_fz);
    check("dn_fn", flag_neg, m_fn);
`endif
    if (ld == 2) check("dn_wrrdy", reg_wr_ready, 0);
    step;
    check("post_done", done, 0);
    if (ld == 2) begin
      check("post_wrrdy", reg_wr_ready, 1);
      step;
      m_rf[la]  = ldd;
      reg_wr_en = 1'b0;
    end
    check_rf;
  endtask

  task automatic clear_model;
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_result = 8'h00;
`ifdef LOGIC_SEQ_FLAGS_EN
    m_fz = 1'b0;
    m_fn = 1'b0;
`endif
  endtask

  initial begin
    logic [7:0] b0;
    logic [7:0] b1;
    reset           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 8'h00;
    reg_wr_en       = 1'b0;
    reg_wr_addr     = 2'd0;
    reg_wr_data     = 8'h00;
    rd_addr         = 2'd0;
    clear_model;
    #2 reset = 1'b1;
    #1;
    check("rst_done", done, 0);
    check("rst_ill", illegal, 0);
    check("rst_res", result, 0);
    check("rst_lu", {lu_opcode, lu_operand_a, lu_operand_b}, 0);
`ifdef LOGIC_SEQ_FLAGS_EN
    check("rst_flags", {flag_zero, flag_neg}, 0);
`endif
    check_rf;
    step;
    step;
    reset = 1'b0;
    step;

    load(2'd0, 8'hF0);
    load(2'd1, 8'h3C);
    send(8'h40, 8'h21, 0, 0, 2'd0, 8'h00);
    check("and_res", result, 8'h30);
    send(8'h43, 8'h31, 0, 0, 2'd0, 8'h00);
    check("nor_res", result, 8'h03);
    send(8'h84, 8'h00, 0, 0, 2'd0, 8'h00);
    send(8'h44, 8'h00, 0, 0, 2'd0, 8'h00);
    send(8'h48, 8'h00, 0, 0, 2'd0, 8'h00);
    load(2'd1, 8'hAA);
    send(8'h42, 8'h15, 0, 2, 2'd2, 8'h77);
    check("nand_rf1", m_rf[1], 8'h55);
    send(8'h41, 8'h0B, 5, 0, 2'd0, 8'h00);

    bus.instr_valid = 1'b1;
    bus.instr       = 8'h40;
    step;
    bus.instr = 8'h21;
    step;
    bus.instr_valid = 1'b0;
    check("pre_rst_op", lu_opcode, 0);
    check("pre_rst_a", lu_operand_a, m_rf[0]);
    reset = 1'b1;
    #1;
    clear_model;
    check("mrst_done", done, 0);
    check("mrst_res", result, 0);
    check("mrst_lu", {lu_opcode, lu_operand_a, lu_operand_b}, 0);
    check_rf;
    step;
    reset = 1'b0;
    step;
    check("mrst_nodone", done, 0);
    step;
    check("mrst_nodone2", done, 0);
    load(2'd0, 8'hF0);
    load(2'd1, 8'h3C);
    send(8'h40, 8'h21, 0, 0, 2'd0, 8'h00);
    check("mrst_res2", result, 8'h30);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0)
        load(2'($urandom), 8'($urandom));
      b0 = 8'($urandom);
      if ($urandom_range(0, 3) != 0) b0[7:6] = 2'b01;
      if ($urandom_range(0, 4) != 0) b0[5:3] = 3'b000;
      b1 = 8'($urandom);
      send(b0, b1, $urandom_range(0, 2), $urandom_range(0, 2),
           2'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
